boreal_mmio_arbiter: RTL and testbench

//  Shares the single-port MMIO register bus (config regs 0x00C-0x019, CSP weights 0x020+) between

---
 rtl/boreal_mmio_pkg.sv | 24 ++
 rtl/boreal_rr_picker.sv | 34 +++
 rtl/boreal_mmio_arbiter.sv | 153 +++++++++++++++
 tb/tb_boreal_mmio_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/boreal_mmio_pkg.sv
// Shared types and constants for the Boreal MMIO arbiter: bus width defaults,
// FSM state encoding and the register-bank address map.
package boreal_mmio_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  // Register-bank address map: config block and the start of the CSP weight table.
  localparam logic [9:0] CFG_FIRST = 10'h00C;
  localparam logic [9:0] CFG_LAST  = 10'h019;
  localparam logic [9:0] CSP_BASE  = 10'h020;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_READ   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  function automatic logic is_mapped(input logic [9:0] addr);
    return ((addr >= CFG_FIRST) && (addr <= CFG_LAST)) || (addr >= CSP_BASE);
  endfunction

endpackage

// File: rtl/boreal_rr_picker.sv
// Rotate-priority encoder: first asserted request scanning ptr+1, ptr+2, ...
// modulo NREQ. Purely combinational.
module boreal_rr_picker #(
  parameter int NREQ  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  int cand;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    winner  = '0;
    win_idx = '0;
    any     = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any && req[cand]) begin
        any     = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
    if (any) winner[win_idx] = 1'b1;
  end

endmodule

// File: rtl/boreal_mmio_arbiter.sv
// Round-robin arbiter sharing the single-port MMIO register bus between NREQ
// requesters, with fixed-latency reads and a watchdog-guarded bus lock.
module boreal_mmio_arbiter
  import boreal_mmio_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 64
) (
  input  logic                     clk_50m,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_din,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  input  logic [DATA_W-1:0]        mem_dout,
  output logic                     busy,
  output logic                     lock_timeout
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam int WD_W  = $clog2(LOCK_MAX + 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;   // requester of the current txn / lock holder
  logic               lock_q, lock_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;

  logic [NREQ-1:0]    gnt_d, rvalid_d;
  logic [DATA_W-1:0]  rdata_d, mem_din_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic               mem_we_d, busy_d, timeout_d;

  logic [NREQ-1:0]    arb_req, pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  // While locked only the owner competes; everyone else is masked off.
  assign arb_req = (state_q == ST_LOCKED) ? (req & (NREQ'(1) << owner_q)) : req;

  boreal_rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
    .req     (arb_req),
    .ptr     (ptr_q),
    .winner  (pick_onehot),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_d     = lock_q;
    lat_d      = lat_q;
    wdog_d     = wdog_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    rdata_d    = rdata;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr;
    mem_din_d  = mem_din;
    timeout_d  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_LOCKED: begin
        if (pick_any) begin
          gnt_d      = pick_onehot;
          ptr_d      = pick_idx;
          owner_d    = pick_idx;
          lock_d     = req_lock[pick_idx];
          wdog_d     = '0;
          lat_d      = '0;
          mem_addr_d = req_addr[pick_idx*ADDR_W +: ADDR_W];
          mem_din_d  = req_din[pick_idx*DATA_W +: DATA_W];
          mem_we_d   = req_we[pick_idx];
          state_d    = req_we[pick_idx] ? ST_WRITE : ST_READ;
        end else if (state_q == ST_LOCKED) begin
          if (wdog_q == WD_W'(LOCK_MAX - 1)) begin
            timeout_d = 1'b1;
            wdog_d    = '0;
            state_d   = ST_IDLE;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        state_d = lock_q ? ST_LOCKED : ST_IDLE;
      end
      ST_READ: begin
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          rdata_d           = mem_dout;
          rvalid_d[owner_q] = 1'b1;
          state_d           = lock_q ? ST_LOCKED : ST_IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= IDX_W'(NREQ - 1);
      owner_q      <= '0;
      lock_q       <= 1'b0;
      lat_q        <= '0;
      wdog_q       <= '0;
      gnt          <= '0;
      rvalid       <= '0;
      rdata        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      busy         <= 1'b0;
      lock_timeout <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      lock_q       <= lock_d;
      lat_q        <= lat_d;
      wdog_q       <= wdog_d;
      gnt          <= gnt_d;
      rvalid       <= rvalid_d;
      rdata        <= rdata_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_din      <= mem_din_d;
      busy         <= busy_d;
      lock_timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_boreal_mmio_arbiter.sv
// Directed bench for boreal_mmio_arbiter: a per-cycle vector table followed by
// hand-written lock, watchdog, reset-abort and random-fairness sequences.
module tb_boreal_mmio_arbiter;

  localparam int NREQ   = 3;
  localparam int AW     = 10;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;
  localparam int LMAX   = 64;

  logic              clk_50m = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req, req_we, req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_din;
  logic [NREQ-1:0]   gnt, rvalid;
  logic [DW-1:0]     rdata, mem_din, mem_dout;
  logic              mem_we, busy, lock_timeout;
  logic [AW-1:0]     mem_addr;

  int n_vec = 0;
  int n_err = 0;

  always #10 clk_50m = ~clk_50m;

  // Register-bank model: combinational read of the presented address.
  function automatic logic [DW-1:0] bank(input logic [AW-1:0] a);
    return (a == 10'h014) ? 32'h0000_7000 : {16'h5A5A, 6'h00, a};
  endfunction

  assign mem_dout = bank(mem_addr);

  boreal_mmio_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .LOCK_MAX(LMAX)
  ) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .req(req), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_din(req_din),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .lock_timeout(lock_timeout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_50m);
  endtask

  task automatic set_req(input int i, input logic en, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]              = en;
    req_we[i]           = we;
    req_lock[i]         = lk;
    req_addr[i*AW +: AW] = a;
    req_din[i*DW +: DW]  = d;
  endtask

  typedef struct {
    logic [2:0]  req, we;
    logic [2:0]  gnt, rvalid;
    logic        mem_we, busy;
    logic [9:0]  addr;
    logic [31:0] din, rdata;
  } vec_t;

  vec_t tbl [17];

  int          bad, max_wait;
  int          waits [NREQ];
  logic [2:0]  pend;

  initial begin
    // Table phase: requester i uses addr 0x00C+i, data 0xD0D00000+i.
    tbl[0]  = '{3'b111, 3'b111, 3'b001, 3'b000, 1'b1, 1'b1, 10'h00C, 32'hD0D0_0000, 32'h0};
    tbl[1]  = '{3'b110, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 10'h00C, 32'hD0D0_0000, 32'h0};
    tbl[2]  = '{3'b110, 3'b111, 3'b010, 3'b000, 1'b1, 1'b1, 10'h00D, 32'hD0D0_0001, 32'h0};
    tbl[3]  = '{3'b100, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 10'h00D, 32'hD0D0_0001, 32'h0};
    tbl[4]  = '{3'b100, 3'b111, 3'b100, 3'b000, 1'b1, 1'b1, 10'h00E, 32'hD0D0_0002, 32'h0};
    tbl[5]  = '{3'b000, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 10'h00E, 32'hD0D0_0002, 32'h0};
    tbl[6]  = '{3'b011, 3'b000, 3'b001, 3'b000, 1'b0, 1'b1, 10'h00C, 32'hD0D0_0000, 32'h0};
    tbl[7]  = '{3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 10'h00C, 32'hD0D0_0000, 32'h0};
    tbl[8]  = '{3'b010, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0, 10'h00C, 32'hD0D0_0000, 32'h5A5A_000C};
    tbl[9]  = '{3'b010, 3'b000, 3'b010, 3'b000, 1'b0, 1'b1, 10'h00D, 32'hD0D0_0001, 32'h5A5A_000C};
    tbl[10] = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 10'h00D, 32'hD0D0_0001, 32'h5A5A_000C};
    tbl[11] = '{3'b000, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 10'h00D, 32'hD0D0_0001, 32'h5A5A_000D};
    tbl[12] = '{3'b101, 3'b001, 3'b100, 3'b000, 1'b0, 1'b1, 10'h00E, 32'hD0D0_0002, 32'h5A5A_000D};
    tbl[13] = '{3'b001, 3'b001, 3'b000, 3'b000, 1'b0, 1'b1, 10'h00E, 32'hD0D0_0002, 32'h5A5A_000D};
    tbl[14] = '{3'b001, 3'b001, 3'b000, 3'b100, 1'b0, 1'b0, 10'h00E, 32'hD0D0_0002, 32'h5A5A_000E};
    tbl[15] = '{3'b001, 3'b001, 3'b001, 3'b000, 1'b1, 1'b1, 10'h00C, 32'hD0D0_0000, 32'h5A5A_000E};
    tbl[16] = '{3'b000, 3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 10'h00C, 32'hD0D0_0000, 32'h5A5A_000E};

    rst_n = 1'b0;
    req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_din = '0;
    repeat (3) tick();
    check("reset_gnt",    {61'h0, gnt},    64'h0);
    check("reset_rvalid", {61'h0, rvalid}, 64'h0);
    check("reset_misc",   {61'h0, mem_we, busy, lock_timeout}, 64'h0);
    check("reset_bus",    {22'h0, mem_addr, mem_din}, 64'h0);
    check("reset_rdata",  {32'h0, rdata},  64'h0);

    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 1'b0, 10'(12 + i), 32'hD0D0_0000 + i);
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      req    = tbl[k].req;
      req_we = tbl[k].we;
      tick();
      check($sformatf("v%0d_gnt", k),    {61'h0, gnt},    {61'h0, tbl[k].gnt});
      check($sformatf("v%0d_rvalid", k), {61'h0, rvalid}, {61'h0, tbl[k].rvalid});
      check($sformatf("v%0d_we_busy", k), {62'h0, mem_we, busy}, {62'h0, tbl[k].mem_we, tbl[k].busy});
      check($sformatf("v%0d_bus", k),    {22'h0, mem_addr, mem_din}, {22'h0, tbl[k].addr, tbl[k].din});
      check($sformatf("v%0d_rdata", k),  {32'h0, rdata},  {32'h0, tbl[k].rdata});
    end

    // Read with RD_LAT=2: rvalid two cycles after the grant cycle.
    set_req(1, 1'b1, 1'b0, 1'b0, 10'h014, 32'h0);
    tick();
    check("rd_gnt", {61'h0, gnt}, 64'b010);
    check("rd_addr", {54'h0, mem_addr}, 64'h014);
    req = '0;
    tick();
    check("rd_wait", {61'h0, rvalid}, 64'h0);
    tick();
    check("rd_rvalid", {61'h0, rvalid}, 64'b010);
    check("rd_rdata", {32'h0, rdata}, 64'h7000);

    // Locked read-modify-write by req0 while req2 requests continuously.
    set_req(0, 1'b1, 1'b0, 1'b1, 10'h017, 32'h0);
    tick();
    check("rmw_gnt_rd", {61'h0, gnt}, 64'b001);
    set_req(0, 1'b1, 1'b1, 1'b0, 10'h017, 32'h0000_1234);
    set_req(2, 1'b1, 1'b1, 1'b0, 10'h019, 32'h0000_BEEF);
    tick();
    check("rmw_t2_gnt", {61'h0, gnt}, 64'h0);
    tick();
    check("rmw_t3_gnt", {61'h0, gnt}, 64'h0);
    check("rmw_rvalid", {61'h0, rvalid}, 64'b001);
    check("rmw_rdata", {32'h0, rdata}, 64'h5A5A_0017);
    check("rmw_busy_locked", {63'h0, busy}, 64'h1);
    tick();
    check("rmw_gnt_wr", {61'h0, gnt}, 64'b001);
    check("rmw_wr_bus", {21'h0, mem_we, mem_addr, mem_din}, {21'h0, 1'b1, 10'h017, 32'h0000_1234});
    req[0] = 1'b0;
    tick();
    check("rmw_t5_gnt", {61'h0, gnt}, 64'h0);
    tick();
    check("rmw_gnt2", {61'h0, gnt}, 64'b100);
    check("rmw_gnt2_addr", {54'h0, mem_addr}, 64'h019);
    req = '0;
    tick();

    // Lock held by idle req1: watchdog release after LOCK_MAX cycles.
    set_req(1, 1'b1, 1'b1, 1'b1, 10'h00D, 32'h0000_0011);
    tick();
    check("wd_gnt1", {61'h0, gnt}, 64'b010);
    req[1] = 1'b0;
    set_req(0, 1'b1, 1'b1, 1'b0, 10'h00C, 32'h0000_0022);
    bad = 0;
    for (int c = 0; c < LMAX; c++) begin
      tick();
      if (gnt != 3'b000 || lock_timeout != 1'b0 || busy != 1'b1) bad++;
    end
    check("wd_hold", 64'(bad), 64'h0);
    tick();
    check("wd_timeout", {62'h0, lock_timeout, busy}, 64'b10);
    check("wd_no_gnt", {61'h0, gnt}, 64'h0);
    tick();
    check("wd_gnt0", {61'h0, gnt}, 64'b001);
    check("wd_pulse_len", {63'h0, lock_timeout}, 64'h0);
    req = '0;
    tick();

    // Reset in the middle of a read aborts it.
    set_req(2, 1'b1, 1'b0, 1'b0, 10'h018, 32'h0);
    tick();
    check("rst_gnt2", {61'h0, gnt}, 64'b100);
    req = '0;
    rst_n = 1'b0;
    tick();
    check("rst_abort", {58'h0, gnt, rvalid}, 64'h0);
    check("rst_abort_misc", {32'h0, rdata}, 64'h0);
    check("rst_abort_we", {62'h0, mem_we, busy}, 64'h0);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (rvalid != 3'b000 || mem_we != 1'b0) bad++;
    end
    check("rst_quiet", 64'(bad), 64'h0);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, 1'b0, 10'(12 + i), 32'h0);
    tick();
    check("rst_first_gnt", {61'h0, gnt}, 64'b001);
    req = '0;
    tick();

    // Random unlocked traffic: exclusivity and round-robin fairness.
    bad = 0;
    max_wait = 0;
    pend = '0;
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($countones(gnt) > 1 || $countones(rvalid) > 1) bad++;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          if (!pend[i]) bad++;
          pend[i]  = 1'b0;
          waits[i] = 0;
          req[i]   = 1'b0;
          for (int j = 0; j < NREQ; j++)
            if (j != i && pend[j]) begin
              waits[j]++;
              if (waits[j] > max_wait) max_wait = waits[j];
            end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          set_req(i, 1'b1, 1'($urandom_range(0, 1)), 1'b0,
                  10'($urandom_range(12, 25)), $urandom);
        end
      end
    end
    check("rand_exclusive", 64'(bad), 64'h0);
    check("rand_starvation", 64'(max_wait <= NREQ - 1), 64'h1);

    req = '0;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
